key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Converts the debounced key-level vector into a stream of key-code events for the calculator core. It detects new presses, arbitrates between simultaneous presses, and generates typematic auto-repeat for the most recently pressed key. Events are buffered in a small FIFO behind a valid/ready handshake. The block sits between the input debouncer and the calculator's command decoder.

## Interface
- WIDTH, 32: number of key lines; CODE_W = $clog2(WIDTH) (localparam)
- FIFO_DEPTH, 4: event buffer entries (power of two, ≥2)
- CLK_FREQ, 50_000_000: clock frequency, Hz
- REPEAT_DELAY_MS, 500: hold time before first repeat
- REPEAT_RATE_MS, 100: period between subsequent repeats
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- keys  in  WIDTH  debounced key levels, 1 = pressed, synchronous to clk
- repeat_en  in  1  auto-repeat enable
- key_valid  out  1  FIFO head holds an event
- key_code  out  CODE_W  key index of head event
- key_repeat  out  1  head event is an auto-repeat (0 = fresh press)
- key_ready  in  1  consumer accepts head event

## Operation
- Edge detect: prev <= keys each cycle; press = keys & ~prev. prev resets to 0.
- Candidates = pending | press. A new press of a key already pending creates no duplicate.
- Each cycle with candidates ≠ 0 and FIFO count < FIFO_DEPTH: enqueue {0, lowest-index candidate}, clear that bit, and set the remaining bits into pending. Otherwise all candidates go into pending.
- Pending is never dropped. A key released before service is still delivered once.
- Repeat FSM states, with DELAY_T = CLK_FREQ/1000*REPEAT_DELAY_MS and RATE_T = CLK_FREQ/1000*REPEAT_RATE_MS:
  - IDLE: on enqueue of a fresh press with code c, set hold_code = c, cnt = 0, go to DELAY.
  - DELAY: cnt increments; at cnt == DELAY_T-1, set rep_req, cnt = 0, go to REPEAT.
  - REPEAT: cnt increments; at cnt == RATE_T-1, set rep_req, cnt = 0.
  - Any state: keys[hold_code] == 0 or repeat_en == 0 → IDLE, rep_req cleared. This has priority over everything except a same-cycle fresh press enqueue.
  - A fresh press enqueued in DELAY/REPEAT retargets: hold_code = new c, cnt = 0, state DELAY, rep_req cleared.
- rep_req: one outstanding at most. A period expiring while it is set merges into it. It is enqueued as {1, hold_code} only in a cycle with no candidates and count < FIFO_DEPTH, then cleared. Fresh presses always win.
- FIFO: first-word-fall-through.
  - Pop when key_valid & key_ready.
  - Push permitted only when registered count < FIFO_DEPTH. A pop while full does not free a slot in the same cycle.
  - Push and pop in the same non-full, non-empty cycle: count unchanged.
- Width rules: cnt sized $clog2(max(DELAY_T, RATE_T)). Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset: key_valid = 0, key_code = 0, key_repeat = 0; FIFO empty, pending = 0, prev = 0, FSM IDLE, cnt = 0, rep_req = 0. Reset is honoured mid-operation; contents are discarded.
- Press latency: keys[i] first sampled high at edge k → entry written at edge k. key_valid is high after k if the FIFO was empty and i was the lowest candidate.
- First repeat: fresh press enqueued at edge k → rep_req set at edge k+DELAY_T → repeat enqueued at k+DELAY_T+1 if unblocked.
- Later repeats: every RATE_T cycles.
- Outputs are registered/FIFO-driven. key_ready has no combinational path to key_valid.

## Structure
- Package calc_key_pkg holds:
  - enum rep_state_t {IDLE, DELAY, REPEAT}
  - function ms_to_ticks(clk_freq, ms)
- Sub-module key_evt_fifo holds the parameterised FWFT FIFO. Parameters: data width CODE_W+1, FIFO_DEPTH. Ports: push/din/full, pop/dout/empty.
- Edge detect, arbiter and repeat FSM live in key_event_ctrl.

## Test plan
Benches use CLK_FREQ=1000, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, so DELAY_T = 5 and RATE_T = 2.
- Press-and-hold: key_ready=1, repeat_en=1, keys[5] rises and holds 12 cycles → fresh event (5,0) one cycle after the rise, then (5,1) at +6, +8, +10, +12 cycles.
- Simultaneous press: key_ready=0, keys[3] and keys[17] rise together → FIFO holds (3,0) then (17,0); hold_code = 17; on key_ready=1 they pop in that order.
- Backpressure: key_ready=0, keys[0..5] rise together → count = 4, pending = {4,5}; raise key_ready → codes 0,1,2,3,4,5 in order, no loss, no duplicates.
- Early release: keys[9] pulses high for 3 cycles → exactly one event (9,0), no repeat. Repeat with repeat_en=0 and a 20-cycle hold → exactly one event.
- Reset mid-repeat: reset asserted while in REPEAT with 2 events queued → key_valid=0 immediately. After release, keys still high produce a fresh press only once prev has cleared (one event).

Source files
------------

// File: rtl/calc_key_pkg.sv
// Shared types and helpers for the calculator key-event path.
//   rep_state_t  : auto-repeat FSM states
//   ms_to_ticks  : converts a millisecond interval into clock ticks
package calc_key_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   // Divide first so that large clock frequencies do not overflow 32 bits.
   function automatic int ms_to_ticks(input int clk_freq, input int ms);
      return (clk_freq / 1000) * ms;
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event buffer for key events.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   full       : registered count has reached DEPTH
//   pop        : read request (ignored while empty)
//   dout       : head entry, forced to zero while empty
//   empty      : no entries held
module key_evt_fifo #(
   parameter int DW    = 6,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   output logic          full,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Status flags, qualified handshakes and head data; all derived from registers only.
   always_comb begin
      full      = (count_r == CNT_FULL);
      empty     = (count_r == {(AW+1){1'b0}});
      do_push_s = push & ~full;
      do_pop_s  = pop & ~empty;
      if (empty) begin
         dout = {DW{1'b0}};
      end else begin
         dout = mem_r[rd_ptr_r];
      end
   end

   // Storage, pointers and occupancy count. A pop while full does not make room
   // for a push in the same cycle because push is gated by the registered count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns debounced key levels into a stream of key-code events with
// lowest-index arbitration, a never-dropping pending set and typematic
// auto-repeat of the most recently pressed key.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   keys        : debounced key levels, 1 = pressed
//   repeat_en   : auto-repeat enable
//   key_valid   : head event present
//   key_code    : key index of the head event (0 when no event)
//   key_repeat  : head event is an auto-repeat
//   key_ready   : consumer accepts the head event
module key_event_ctrl
   import calc_key_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int CLK_FREQ        = 50_000_000,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         keys,
   input  logic                     repeat_en,
   output logic                     key_valid,
   output logic [$clog2(WIDTH)-1:0] key_code,
   output logic                     key_repeat,
   input  logic                     key_ready
);

   localparam int CODE_W  = $clog2(WIDTH);
   localparam int DELAY_T = ms_to_ticks(CLK_FREQ, REPEAT_DELAY_MS);
   localparam int RATE_T  = ms_to_ticks(CLK_FREQ, REPEAT_RATE_MS);
   localparam int MAX_T   = (DELAY_T > RATE_T) ? DELAY_T : RATE_T;
   localparam int CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(DELAY_T - 1);
   localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(RATE_T - 1);
   localparam logic [WIDTH-1:0] BIT_ZERO  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [CODE_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = {CODE_W{1'b0}};
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = CODE_W'(i);
         end
      end
      return idx;
   endfunction

   logic [WIDTH-1:0]  prev_r;
   logic [WIDTH-1:0]  pending_r;
   logic [WIDTH-1:0]  pending_s;
   logic [WIDTH-1:0]  press_s;
   logic [WIDTH-1:0]  cand_s;
   logic [WIDTH-1:0]  sel_mask_s;
   logic [CODE_W-1:0] sel_code_s;
   logic [CODE_W-1:0] hold_code_r;
   logic [CODE_W-1:0] hold_code_s;
   rep_state_t        state_r;
   rep_state_t        state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_s;
   logic              rep_req_r;
   logic              rep_req_s;
   logic              fresh_enq_s;
   logic              rep_enq_s;
   logic              held_s;
   logic              push_s;
   logic              pop_s;
   logic [CODE_W:0]   din_s;
   logic [CODE_W:0]   dout_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;

   // Edge detect and arbitration: fresh presses (new or pending) always beat a repeat.
   always_comb begin
      press_s     = keys & ~prev_r;
      cand_s      = pending_r | press_s;
      sel_code_s  = lowest_idx(cand_s);
      sel_mask_s  = BIT_ZERO << sel_code_s;
      fresh_enq_s = (cand_s != {WIDTH{1'b0}}) && !fifo_full_s;
      rep_enq_s   = (cand_s == {WIDTH{1'b0}}) && !fifo_full_s && rep_req_r;
      push_s      = fresh_enq_s | rep_enq_s;
      if (fresh_enq_s) begin
         pending_s = cand_s & ~sel_mask_s;
         din_s     = {1'b0, sel_code_s};
      end else if (rep_enq_s) begin
         pending_s = cand_s;
         din_s     = {1'b1, hold_code_r};
      end else begin
         pending_s = cand_s;
         din_s     = {(CODE_W+1){1'b0}};
      end
   end

   // Repeat FSM next state. A fresh enqueue retargets; otherwise losing the held
   // key or the enable returns to IDLE. A consumed request can be re-armed by a
   // period that expires in the same cycle.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      hold_code_s = hold_code_r;
      rep_req_s   = rep_req_r & ~rep_enq_s;
      held_s      = keys[hold_code_r] & repeat_en;
      if (fresh_enq_s) begin
         hold_code_s = sel_code_s;
         cnt_s       = {CNT_W{1'b0}};
         state_s     = DELAY;
         rep_req_s   = 1'b0;
      end else if (!held_s) begin
         cnt_s     = {CNT_W{1'b0}};
         state_s   = IDLE;
         rep_req_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_s = {CNT_W{1'b0}};
            end
            DELAY: begin
               if (cnt_r == DELAY_END) begin
                  rep_req_s = 1'b1;
                  cnt_s     = {CNT_W{1'b0}};
                  state_s   = REPEAT;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            REPEAT: begin
               if (cnt_r == RATE_END) begin
                  rep_req_s = 1'b1;
                  cnt_s     = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               cnt_s     = {CNT_W{1'b0}};
               state_s   = IDLE;
               rep_req_s = 1'b0;
            end
         endcase
      end
   end

   // Edge-detect history, pending set and repeat FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r      <= {WIDTH{1'b0}};
         pending_r   <= {WIDTH{1'b0}};
         hold_code_r <= {CODE_W{1'b0}};
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         rep_req_r   <= 1'b0;
      end else begin
         prev_r      <= keys;
         pending_r   <= pending_s;
         hold_code_r <= hold_code_s;
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         rep_req_r   <= rep_req_s;
      end
   end

   key_evt_fifo #(
      .DW    (CODE_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .din   (din_s),
      .full  (fifo_full_s),
      .pop   (pop_s),
      .dout  (dout_s),
      .empty (fifo_empty_s)
   );

   // Outputs come straight from FIFO registers; key_ready only feeds the pop.
   always_comb begin
      key_valid  = ~fifo_empty_s;
      key_code   = dout_s[CODE_W-1:0];
      key_repeat = dout_s[CODE_W];
      pop_s      = ~fifo_empty_s & key_ready;
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with DELAY_T = 5 and RATE_T = 2.
module tb_key_event_ctrl;

   localparam int W  = 32;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  keys = '0;
   logic          repeat_en = 1'b1;
   logic          key_valid;
   logic [CW-1:0] key_code;
   logic          key_repeat;
   logic          key_ready = 1'b0;

   key_event_ctrl #(
      .WIDTH           (W),
      .FIFO_DEPTH      (4),
      .CLK_FREQ        (1000),
      .REPEAT_DELAY_MS (5),
      .REPEAT_RATE_MS  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys       (keys),
      .repeat_en  (repeat_en),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_repeat (key_repeat),
      .key_ready  (key_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int code;
      int rep;
      int t;
   } ev_t;
   ev_t ev_q[$];

   // Log every event that will be popped at the next rising edge.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n && key_valid && key_ready) begin
         e.code = int'(key_code);
         e.rep  = int'(key_repeat);
         e.t    = cyc;
         ev_q.push_back(e);
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic [W-1:0]  keys;
      bit            rdy;
      bit            v;
      int            code;
      bit            rep;
   } vec_t;
   vec_t vt[$];

   task automatic add_vec(input logic [W-1:0] k, input bit rdy, input bit v,
                          input int code, input bit rep);
      vec_t x;
      x.keys = k; x.rdy = rdy; x.v = v; x.code = code; x.rep = rep;
      vt.push_back(x);
   endtask

   task automatic check_events(input string name, input int n_exp,
                               input int codes[5], input int reps[5], input int offs[5]);
      check({name, "_count"}, ev_q.size(), n_exp);
      for (int i = 0; i < n_exp && i < ev_q.size(); i++) begin
         check($sformatf("%s_code%0d", name, i), ev_q[i].code, codes[i]);
         check($sformatf("%s_rep%0d", name, i), ev_q[i].rep, reps[i]);
         check($sformatf("%s_t%0d", name, i), ev_q[i].t - ev_q[0].t, offs[i]);
      end
   endtask

   initial begin
      logic [W-1:0] k3_17;
      logic [W-1:0] k17;
      logic [W-1:0] k0_5;
      k3_17 = (32'd1 << 3) | (32'd1 << 17);
      k17   = 32'd1 << 17;
      k0_5  = 32'h0000_003F;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(key_valid), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_repeat", int'(key_repeat), 0);
      rst_n = 1'b1;

      // Simultaneous press of 3 and 17, then hold 17 into auto-repeat
      add_vec('0,    0, 0, 0,  0);
      add_vec(k3_17, 0, 1, 3,  0);
      add_vec(k3_17, 0, 1, 3,  0);
      add_vec(k3_17, 1, 1, 17, 0);
      add_vec(k17,   1, 0, 0,  0);
      add_vec(k17,   1, 0, 0,  0);
      add_vec(k17,   1, 0, 0,  0);
      add_vec(k17,   1, 0, 0,  0);
      add_vec(k17,   1, 1, 17, 1);
      add_vec(k17,   1, 0, 0,  0);
      add_vec(k17,   1, 1, 17, 1);
      add_vec('0,    1, 0, 0,  0);
      add_vec('0,    1, 0, 0,  0);
      add_vec('0,    1, 0, 0,  0);
      // Backpressure: six simultaneous presses into a four-entry buffer
      add_vec(k0_5,  0, 1, 0,  0);
      add_vec(k0_5,  0, 1, 0,  0);
      add_vec(k0_5,  0, 1, 0,  0);
      add_vec(k0_5,  0, 1, 0,  0);
      add_vec(k0_5,  0, 1, 0,  0);
      add_vec(k0_5,  1, 1, 1,  0);
      add_vec(k0_5,  1, 1, 2,  0);
      add_vec(k0_5,  1, 1, 3,  0);
      add_vec(k0_5,  1, 1, 4,  0);
      add_vec(k0_5,  1, 1, 5,  0);
      add_vec(k0_5,  1, 0, 0,  0);
      add_vec('0,    1, 0, 0,  0);
      add_vec('0,    1, 0, 0,  0);

      for (int i = 0; i < vt.size(); i++) begin
         keys      = vt[i].keys;
         key_ready = vt[i].rdy;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), int'(key_valid), int'(vt[i].v));
         check($sformatf("vec%0d_code", i), int'(key_code), vt[i].code);
         check($sformatf("vec%0d_repeat", i), int'(key_repeat), int'(vt[i].rep));
      end

      // Press and hold key 5: fresh event then repeats at +6, +8, +10, +12
      keys = '0; key_ready = 1'b1; repeat_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ev_q.delete();
      keys = 32'd1 << 5;
      repeat (13) @(posedge clk);
      #1;
      keys = '0;
      repeat (10) @(posedge clk);
      #1;
      check_events("hold", 5, '{5, 5, 5, 5, 5}, '{0, 1, 1, 1, 1}, '{0, 6, 8, 10, 12});

      // Early release: one fresh event, no repeat
      ev_q.delete();
      keys = 32'd1 << 9;
      repeat (3) @(posedge clk);
      #1;
      keys = '0;
      repeat (20) @(posedge clk);
      #1;
      check_events("early", 1, '{9, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

      // Long hold with repeat disabled: still exactly one event
      ev_q.delete();
      repeat_en = 1'b0;
      keys = 32'd1 << 12;
      repeat (20) @(posedge clk);
      #1;
      keys = '0;
      repeat (5) @(posedge clk);
      #1;
      repeat_en = 1'b1;
      check_events("norep", 1, '{12, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

      // Reset in REPEAT with two events queued
      key_ready = 1'b0;
      keys = 32'd1 << 7;
      repeat (7) @(posedge clk);
      #1;
      check("mid_valid", int'(key_valid), 1);
      check("mid_code", int'(key_code), 7);
      check("mid_repeat", int'(key_repeat), 0);
      rst_n = 1'b0;
      #1;
      check("arst_valid", int'(key_valid), 0);
      check("arst_code", int'(key_code), 0);
      check("arst_repeat", int'(key_repeat), 0);
      @(posedge clk);
      #1;
      ev_q.delete();
      key_ready = 1'b1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      keys = '0;
      repeat (10) @(posedge clk);
      #1;
      check_events("post_rst", 1, '{7, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
